// File: rtl/obi_resp_pkg.sv
// Shared types and parameter limits for the OBI memory responder.
// The response FIFO and the top-level responder both import this package.
package obi_resp_pkg;

   localparam int MEM_WORDS_MIN = 2;
   localparam int MAX_PND_MIN   = 1;
   localparam int MAX_PND_MAX   = 3;
   localparam int RESP_LAT_MIN  = 1;
   localparam int RESP_LAT_MAX  = 7;

   typedef struct packed {
      logic [31:0] rdata;
      logic [2:0]  age;
   } resp_entry_t;

   // Age advances once per cycle and parks at the response latency.
   function automatic logic [2:0] age_step(input logic [2:0] age, input int lat);
      return (age < 3'(lat)) ? age + 3'd1 : age;
   endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response FIFO. Entry 0 is always the head, and every stored
// entry ages by one each cycle.
module obi_resp_fifo
   import obi_resp_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int RESP_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  logic [31:0] push_rdata,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output logic [1:0]  count,
   output logic [31:0] head_rdata,
   output logic [2:0]  head_age
);

   resp_entry_t entries      [DEPTH];
   resp_entry_t entries_next [DEPTH];
   logic [1:0]  count_q;
   logic [1:0]  count_next;
   logic [1:0]  wr_idx;

   // NOTE: every variable written here gets a default first, so no latches can be inferred.
   always_comb begin
      count_next = count_q;
      wr_idx     = pop ? count_q - 2'd1 : count_q;
      if (push && !pop) begin
         count_next = count_q + 2'd1;
      end else if (pop && !push) begin
         count_next = count_q - 2'd1;
      end

      for (int i = 0; i < DEPTH - 1; i++) begin
         entries_next[i] = pop ? entries[i + 1] : entries[i];
      end
      entries_next[DEPTH - 1] = pop ? '0 : entries[DEPTH - 1];

      for (int i = 0; i < DEPTH; i++) begin
         entries_next[i].age = age_step(entries_next[i].age, RESP_LAT);
         if (push && wr_idx == 2'(i)) begin
            entries_next[i] = '{rdata: push_rdata, age: 3'd1};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         count_q <= count_next;
         entries <= entries_next;
      end
   end

   assign full       = (count_q == 2'(DEPTH));
   assign empty      = (count_q == 2'd0);
   assign count      = count_q;
   assign head_rdata = entries[0].rdata;
   assign head_age   = entries[0].age;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI-style memory responder: word-addressed memory with byte-enable writes
// and in-order responses delayed by at least RESP_LAT cycles after grant.
module obi_mem_responder
   import obi_resp_pkg::*;
#(
   parameter int MEM_WORDS = 16,
   parameter int MAX_PND   = 2,
   parameter int RESP_LAT  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   input  logic        stall_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  pnd_o
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [31:0]      mem [MEM_WORDS];
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             fifo_full;
   logic             fifo_empty;
   logic [31:0]      head_rdata;
   logic [2:0]       head_age;
   logic [31:0]      push_rdata;
   logic             unused_addr;

   // Upper address bits alias onto the same words; byte-offset bits are ignored.
   assign idx         = addr_i[IDX_W+1:2];
   assign unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

   assign rvalid_o = !fifo_empty && (head_age == 3'(RESP_LAT));
   assign gnt_o    = !reset && req_i && !stall_i && (!fifo_full || rvalid_o);
   assign accept   = req_i && gnt_o;
   assign rdata_o  = rvalid_o ? head_rdata : '0;

   // Reads see the word before this edge's write, which is always a different transaction.
   assign push_rdata = we_i ? '0 : mem[idx];

   // NOTE: the memory is reset explicitly because reads after reset must return zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (accept && we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   obi_resp_fifo #(
      .DEPTH    (MAX_PND),
      .RESP_LAT (RESP_LAT)
   ) u_resp_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (accept),
      .push_rdata (push_rdata),
      .pop        (rvalid_o),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (pnd_o),
      .head_rdata (head_rdata),
      .head_age   (head_age)
   );

endmodule

// File: tb/tb_obi_mem_responder.sv
// Drives two responders (RESP_LAT 1 and 3) with shared stimulus and compares
// each against a transaction-level model of grants, memory and response times.
module tb_obi_mem_responder;

   localparam int MAXP = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req   = 1'b0;
   logic [31:0] addr  = '0;
   logic        we    = 1'b0;
   logic [3:0]  be    = '0;
   logic [31:0] wdata = '0;
   logic        stall = 1'b0;

   logic        gnt    [2];
   logic        rvalid [2];
   logic [31:0] rdata  [2];
   logic [1:0]  pnd    [2];

   int unsigned cyc;
   int          n_assert;
   int          n_fail;

   // Model: outstanding responses per DUT as (cycle it becomes due, data).
   int unsigned p_ready [2][4];
   logic [31:0] p_data  [2][4];
   int          p_cnt   [2];
   logic [31:0] ref_mem [2][16];

   always #5 clock = ~clock;

   obi_mem_responder #(.MEM_WORDS(16), .MAX_PND(MAXP), .RESP_LAT(1)) u_lat1 (
      .clock(clock), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .stall_i(stall), .gnt_o(gnt[0]),
      .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .pnd_o(pnd[0])
   );

   obi_mem_responder #(.MEM_WORDS(16), .MAX_PND(MAXP), .RESP_LAT(3)) u_lat3 (
      .clock(clock), .reset(reset), .req_i(req), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .stall_i(stall), .gnt_o(gnt[1]),
      .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .pnd_o(pnd[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] wd, input logic s);
      req = r; addr = a; we = w; be = b; wdata = wd; stall = s;
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         p_cnt[d] = 0;
         for (int i = 0; i < 16; i++) ref_mem[d][i] = '0;
      end
   endtask

   // One clock cycle: compare outputs with the model, advance the model, tick.
   task automatic step();
      logic        eg;
      logic        ev;
      logic [31:0] ed;
      int          idx;
      #1;
      idx = int'(addr[5:2]);
      for (int d = 0; d < 2; d++) begin
         ev = (p_cnt[d] > 0) && (p_ready[d][0] <= cyc);
         ed = ev ? p_data[d][0] : 32'h0;
         eg = req && !stall && ((p_cnt[d] < MAXP) || ev);
         check($sformatf("u%0d gnt c%0d", d, cyc),    32'(gnt[d]),    32'(eg));
         check($sformatf("u%0d rvalid c%0d", d, cyc), 32'(rvalid[d]), 32'(ev));
         check($sformatf("u%0d rdata c%0d", d, cyc),  rdata[d],       ed);
         check($sformatf("u%0d pnd c%0d", d, cyc),    32'(pnd[d]),    32'(p_cnt[d]));
         if (ev) begin
            for (int k = 0; k < 3; k++) begin
               p_ready[d][k] = p_ready[d][k + 1];
               p_data[d][k]  = p_data[d][k + 1];
            end
            p_cnt[d]--;
         end
         if (eg) begin
            p_ready[d][p_cnt[d]] = cyc + lat_of(d);
            p_data[d][p_cnt[d]]  = we ? 32'h0 : ref_mem[d][idx];
            p_cnt[d]++;
            if (we) begin
               for (int b = 0; b < 4; b++) begin
                  if (be[b]) ref_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
               end
            end
         end
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("u%0d rst gnt", d),    32'(gnt[d]),    32'h0);
         check($sformatf("u%0d rst rvalid", d), 32'(rvalid[d]), 32'h0);
         check($sformatf("u%0d rst rdata", d),  rdata[d],       32'h0);
         check($sformatf("u%0d rst pnd", d),    32'(pnd[d]),    32'h0);
      end
      model_clear();
      @(posedge clock);
      cyc++;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cyc      = 0;
      n_assert = 0;
      n_fail   = 0;
      model_clear();
      @(negedge clock);

      // Reset with a request pending: no grant may leak out.
      drive(1'b1, 32'h8, 1'b0, 4'hF, 32'h0, 1'b0);
      do_reset();

      // Full-word write then read-back.
      drive(1'b1, 32'h8, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0);
      step();
      drive(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("wr-rd rvalid", 32'(rvalid[0]), 32'h1);
      check("wr-rd rdata",  rdata[0],       32'hDEADBEEF);
      idle(5);

      // Partial write over a known word.
      drive(1'b1, 32'hC, 1'b1, 4'hF, 32'h11223344, 1'b0);
      step();
      drive(1'b1, 32'hC, 1'b1, 4'h2, 32'h0000AA00, 1'b0);
      step();
      drive(1'b1, 32'hC, 1'b0, 4'h0, 32'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("partial rvalid", 32'(rvalid[0]), 32'h1);
      check("partial rdata",  rdata[0],       32'h1122AA44);
      idle(6);

      // Address aliasing: 0x40 and 0x0 share a word.
      drive(1'b1, 32'h40, 1'b1, 4'hF, 32'h5, 1'b0);
      step();
      drive(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("alias rvalid", 32'(rvalid[0]), 32'h1);
      check("alias rdata",  rdata[0],       32'h5);
      idle(6);

      // Back-to-back reads with req held: the latency-3 unit fills up.
      drive(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b0);
      step();
      addr = 32'hC;
      step();
      addr = 32'h0;
      #1;
      check("b2b gnt full", 32'(gnt[1]), 32'h0);
      check("b2b pnd full", 32'(pnd[1]), 32'h2);
      step();
      #1;
      check("b2b rvalid first", 32'(rvalid[1]), 32'h1);
      check("b2b rdata first",  rdata[1],       32'hDEADBEEF);
      check("b2b gnt on pop",   32'(gnt[1]),    32'h1);
      for (int i = 0; i < 5; i++) begin
         addr = 32'(4 * i);
         step();
      end
      idle(7);

      // Stall blocks grants without disturbing anything else.
      drive(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step();
      stall = 1'b0;
      #1;
      check("stall release gnt", 32'(gnt[0]), 32'h1);
      step();
      idle(5);

      // Reset while a read is outstanding discards its response and the memory.
      drive(1'b1, 32'h10, 1'b1, 4'hF, 32'h77, 1'b0);
      step();
      idle(5);
      drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("mid-rst pnd before", 32'(pnd[1]), 32'h1);
      do_reset();
      idle(5);
      drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
      #1;
      check("post-rst rvalid", 32'(rvalid[0]), 32'h1);
      check("post-rst rdata",  rdata[0],       32'h0);
      idle(5);

      // Random traffic, with an occasional reset.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 4) == 0);
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            step();
         end
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16, meaning word depth of the internal memory (power of two, at least 2).
REQ-002 SHALL have parameter MAX_PND, default 2, meaning the maximum number of granted-but-unanswered transactions (1 to 3).
REQ-003 SHALL have parameter RESP_LAT, default 1, meaning the minimum number of cycles from grant to rvalid (1 to 7).
REQ-004 SHALL have port clock, input, width 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, width 1: reset, asynchronous and active-high.
REQ-006 SHALL have port req_i, input, width 1: request from the core-side initiator.
REQ-007 SHALL have port addr_i, input, width 32: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port we_i, input, width 1: 1 = write, 0 = read.
REQ-009 SHALL have port be_i, input, width 4: byte enables for writes.
REQ-010 SHALL have port wdata_i, input, width 32: write data.
REQ-011 SHALL have port stall_i, input, width 1: grant throttle (free or random under formal).
REQ-012 SHALL have port gnt_o, output, width 1: request accepted this cycle.
REQ-013 SHALL have port rvalid_o, output, width 1: response valid, one cycle per transaction.
REQ-014 SHALL have port rdata_o, output, width 32: read data, valid with rvalid_o.
REQ-015 SHALL have port pnd_o, output, width 2: current outstanding-transaction count.

Function
REQ-016 gnt_o SHALL be combinational: req_i && !stall_i && (pnd_o < MAX_PND || rvalid_o).
REQ-017 A transaction SHALL be accepted only in a cycle where req_i && gnt_o holds; addr/we/be/wdata are sampled in that cycle.
REQ-018 The word index SHALL be addr_i[log2(MEM_WORDS)+1:2]; higher address bits alias silently.
REQ-019 An accepted write SHALL update only the bytes with be_i set, at the accepting clock edge.
REQ-020 An accepted read SHALL capture the word at the accepting edge, so it includes every earlier-accepted write and excludes writes accepted later.
REQ-021 Each accepted transaction SHALL push an entry {rdata, age} into an in-order response FIFO of depth MAX_PND; write entries carry rdata 0.
REQ-022 The age SHALL start at 1 on push and increment each cycle, saturating at RESP_LAT.
REQ-023 rvalid_o SHALL be 1 only when the FIFO is non-empty and the head age equals RESP_LAT; the head pops in that same cycle.
REQ-024 As a consequence of REQ-023, rvalid_o asserts at the earliest RESP_LAT cycles after grant, exactly one per transaction, in grant order.
REQ-025 rdata_o SHALL equal the head rdata while rvalid_o=1 and SHALL be 0 otherwise.
REQ-026 The pnd count SHALL update as follows: +1 on accept only; -1 on rvalid only; unchanged on simultaneous accept and rvalid.
REQ-027 The pnd count SHALL never exceed MAX_PND and SHALL never go below 0.
REQ-028 When full, accept is allowed only in a cycle that also pops (REQ-016).
REQ-029 No rvalid_o SHALL ever occur with pnd_o == 0.
REQ-030 stall_i and req_i low SHALL not affect responses already in flight.

Reset
REQ-031 While reset is high, gnt_o, rvalid_o, rdata_o and pnd_o SHALL be 0, the FIFO SHALL be empty, and all memory words SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL discard all outstanding responses; no rvalid_o SHALL appear for them after deassertion.

Structure
REQ-033 Package obi_resp_pkg SHALL hold resp_entry_t {rdata[31:0], age[2:0]} and the constant ranges for the parameters.
REQ-034 The response FIFO SHALL be sub-module obi_resp_fifo, parameterised by depth, with push/pop/full/empty/count and the head entry.
REQ-035 The memory array, address decode and gnt logic SHALL stay in obi_mem_responder.

Verification
REQ-036 Write then read, RESP_LAT=1, stall_i=0: write 0xDEADBEEF, be=0xF to addr 0x8, then read 0x8 -> rvalid one cycle after each grant, second rdata 0xDEADBEEF.
REQ-037 Partial write: memory word 0x11223344, write be=0x2 wdata 0x0000AA00 -> read returns 0x1122AA44.
REQ-038 Back-to-back reads, RESP_LAT=3, MAX_PND=2, req_i held -> gnt low on the third request until the first rvalid; pnd_o never reaches 3; responses in order.
REQ-039 stall_i=1 for 5 cycles with req_i=1 -> no gnt, no rvalid, pnd_o=0; first gnt in the cycle stall_i drops.
REQ-040 Aliasing, MEM_WORDS=16: write 0x5 to 0x40 -> read of 0x0 returns 0x5.
REQ-041 Reset at the cycle after grant with pnd_o=1 -> rvalid_o stays 0 and pnd_o=0 afterwards; read of that address returns 0.
